// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   state_t        : sequencer FSM state, also driven out on the state port
//   LOSS_CTR_WIDTH : width of the saturating lock-loss event counter
package rst_seq_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_CTR_WIDTH = 8;
endpackage

// File: rtl/sync_bit.sv
// Single-bit multi-flop synchroniser for an asynchronous input.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : d delayed through SYNC_STAGES flops
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];
endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: qualifies PLL lock, holds all domain resets for
// HOLD_CYCLES, then releases them one by one every STAGGER_CYCLES.
// Re-sequences on lock loss (via WAIT_LOCK) or on a warm-reset request
// (straight back to HOLD).
//   clk             : system clock
//   rst_n           : synchronous active-low reset
//   pll_locked      : PLL lock, asynchronous
//   sw_rst_req      : single-cycle warm-reset request
//   rst_n_out       : per-domain active-low resets, released in index order
//   ready           : all domains released
//   state           : current FSM state
//   lock_loss_count : saturating count of lock-loss events
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST        = 4,
  parameter int HOLD_CYCLES    = 100,
  parameter int STAGGER_CYCLES = 16,
  parameter int CTR_WIDTH      = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pll_locked,
  input  logic                      sw_rst_req,
  output logic [NUM_RST-1:0]        rst_n_out,
  output logic                      ready,
  output logic [1:0]                state,
  output logic [LOSS_CTR_WIDTH-1:0] lock_loss_count
);
  localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  logic                      lock_s;
  state_t                    state_q, state_d;
  logic [CTR_WIDTH-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_RST-1:0]        rst_q, rst_d;
  logic                      ready_q, ready_d;
  logic [LOSS_CTR_WIDTH-1:0] loss_q, loss_d;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      loss_q  <= loss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    loss_d  = loss_q;
    if (state_q == WAIT_LOCK) begin
      // warm reset is meaningless without lock, so sw_rst_req is ignored here
      rst_d   = '0;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      if (lock_s) state_d = HOLD;
    end else if (!lock_s) begin
      // lock loss takes priority over a coincident warm-reset request
      state_d = WAIT_LOCK;
      rst_d   = '0;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
      if (loss_q != '1) loss_d = loss_q + LOSS_CTR_WIDTH'(1);
    end else if (sw_rst_req) begin
      state_d = HOLD;
      rst_d   = '0;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end else if (state_q == HOLD) begin
      if (cnt_q == CTR_WIDTH'(HOLD_CYCLES - 1)) begin
        state_d = RELEASE;
        cnt_d   = '0;
        idx_d   = '0;
      end else begin
        cnt_d = cnt_q + CTR_WIDTH'(1);
      end
    end else if (state_q == RELEASE) begin
      if (cnt_q == CTR_WIDTH'(STAGGER_CYCLES - 1)) begin
        rst_d[idx_q] = 1'b1;
        cnt_d        = '0;
        if (idx_q == IDX_W'(NUM_RST - 1)) begin
          state_d = RUN;
          ready_d = 1'b1;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CTR_WIDTH'(1);
      end
    end else begin
      rst_d   = '1;
      ready_d = 1'b1;
    end
  end

  assign rst_n_out       = rst_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_q;
endmodule
